// File: rtl/prod_sched_pkg.sv
// Shared definitions for the producer scheduler: state encoding, LED bit
// positions and default widths.
package prod_sched_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_CNT_W  = 16;

  // Bit positions of each state in the one-hot encoding and on the LEDs
  localparam int LED_IDLE   = 0;
  localparam int LED_COMM_F = 1;
  localparam int LED_WAIT_F = 2;
  localparam int LED_COMM_T = 3;
  localparam int LED_WAIT_T = 4;
  localparam int LED_DRAIN  = 5;
  localparam int N_STATES   = 6;

  typedef enum logic [N_STATES-1:0] {
    S_IDLE   = 6'b000001,
    S_COMM_F = 6'b000010,
    S_WAIT_F = 6'b000100,
    S_COMM_T = 6'b001000,
    S_WAIT_T = 6'b010000,
    S_DRAIN  = 6'b100000
  } state_t;

  function automatic logic is_wait(input state_t s);
    return s[LED_WAIT_F] | s[LED_WAIT_T];
  endfunction

endpackage

// File: rtl/prod_sched_skid.sv
// One-entry holding register that parks an accepted word while the buffer
// is full. A load into an occupied entry is ignored so the older word wins.
module skid_reg #(
  parameter int W = 17
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         unload,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         valid
);

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          valid <= 1'b0;
    else if (unload)  valid <= 1'b0;
    else if (load)    valid <= 1'b1;
  end

  // NOTE: the payload carries no reset; valid alone qualifies it, so
  // resetting the data would only add reset fan-out.
  always_ff @(posedge clk) begin
    if (load && !valid) dout <= din;
  end

endmodule

// File: rtl/prod_sched.sv
// Producer scheduler: sequences Fibonacci/Timer production, gates producer
// enables and funnels accepted words into the buffer with full backpressure.
module prod_sched
  import prod_sched_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_f_p,
  input  logic              start_t_p,
  input  logic              stop_p,
  input  logic              f_valid,
  input  logic [DATA_W-1:0] f_data,
  input  logic              t_valid,
  input  logic [DATA_W-1:0] t_data,
  input  logic              buf_full,
  input  logic              buf_empty,
  input  logic              cons_valid,
  output logic              f_en,
  output logic              t_en,
  output logic              buf_wr,
  output logic [DATA_W-1:0] buf_wdata,
  output logic              src_sel,
  output logic [CNT_W-1:0]  wr_count,
  output logic [5:0]        state_led
);

  state_t            state;
  logic              sel_t;
  logic              acc_valid;
  logic [DATA_W-1:0] acc_data;
  logic              skid_v;
  logic              skid_load;
  logic              skid_unload;
  logic              direct_wr;
  logic              wr_go;
  logic [DATA_W:0]   skid_dout;
  logic [DATA_W:0]   wr_word;

  // Enables and LEDs decode straight from the one-hot state register
  assign state_led = state;
  assign f_en      = state[LED_COMM_F];
  assign t_en      = state[LED_COMM_T];

  always_comb begin
    // NOTE: every signal gets a value on every path, so no latch is inferred.
    sel_t     = state[LED_COMM_T];
    acc_valid = 1'b0;
    if (state == S_COMM_F)      acc_valid = f_valid;
    else if (state == S_COMM_T) acc_valid = t_valid;
    acc_data    = sel_t ? t_data : f_data;
    // The parked word always leaves before anything newer
    skid_unload = skid_v && !buf_full && (is_wait(state) || state == S_DRAIN);
    skid_load   = acc_valid && buf_full && !skid_v;
    direct_wr   = acc_valid && !buf_full && !skid_v;
    wr_go       = skid_unload || direct_wr;
    wr_word     = skid_unload ? skid_dout : {sel_t, acc_data};
  end

  skid_reg #(.W(DATA_W + 1)) u_skid (
    .clk    (clk),
    .rst    (rst),
    .load   (skid_load),
    .unload (skid_unload),
    .din    ({sel_t, acc_data}),
    .dout   (skid_dout),
    .valid  (skid_v)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      buf_wr    <= 1'b0;
      buf_wdata <= '0;
      src_sel   <= 1'b0;
      wr_count  <= '0;
    end else begin
      buf_wr <= wr_go;
      if (wr_go) begin
        buf_wdata <= wr_word[DATA_W-1:0];
        src_sel   <= wr_word[DATA_W];
        wr_count  <= wr_count + CNT_W'(1);
      end

      unique case (state)
        S_IDLE: begin
          // No write can be in flight here, so clearing the count is safe
          if (start_f_p) begin
            state    <= S_COMM_F;
            wr_count <= '0;
          end else if (start_t_p) begin
            state    <= S_COMM_T;
            wr_count <= '0;
          end
        end
        S_COMM_F: begin
          if (stop_p)        state <= S_DRAIN;
          else if (buf_full) state <= S_WAIT_F;
        end
        S_COMM_T: begin
          if (stop_p)        state <= S_DRAIN;
          else if (buf_full) state <= S_WAIT_T;
        end
        S_WAIT_F: begin
          if (stop_p)                    state <= S_DRAIN;
          else if (!buf_full && !skid_v) state <= S_COMM_F;
        end
        S_WAIT_T: begin
          if (stop_p)                    state <= S_DRAIN;
          else if (!buf_full && !skid_v) state <= S_COMM_T;
        end
        S_DRAIN: begin
          if (buf_empty && !cons_valid && !skid_v) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/prod_sched.md
# prod_sched

Producer scheduler for the Fibonacci/Timer data path. It sequences which producer runs, gates the producer enables, and funnels the selected producer's words into the shared buffer write port. It applies buffer-full backpressure without losing words and drives the drain phase until the consumer side is empty. It sits between the edge-detected front-panel pulses, the two producers and the buffer wrapper, and exports a one-hot state for the LEDs.

## Interface
- DATA_W, 16, producer/buffer word width
- CNT_W, 16, width of the per-session written-word counter
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- start_f_p  in  1  single-cycle pulse, start/resume Fibonacci production
- start_t_p  in  1  single-cycle pulse, start/resume Timer production
- stop_p  in  1  single-cycle pulse, stop production and drain
- f_valid  in  1  Fibonacci word valid (one cycle per word)
- f_data  in  DATA_W  Fibonacci word
- t_valid  in  1  Timer word valid
- t_data  in  DATA_W  Timer word
- buf_full  in  1  buffer cannot accept a write this cycle
- buf_empty  in  1  buffer holds no words
- cons_valid  in  1  consumer still holds an undisplayed word
- f_en  out  1  Fibonacci producer enable
- t_en  out  1  Timer producer enable
- buf_wr  out  1  buffer write strobe
- buf_wdata  out  DATA_W  buffer write data
- src_sel  out  1  source of the last accepted word: 0 = Fibonacci, 1 = Timer
- wr_count  out  CNT_W  words written to the buffer this session
- state_led  out  6  one-hot state: bit0 IDLE … bit5 DRAIN

## Operation
- States: IDLE, COMM_F, WAIT_F, COMM_T, WAIT_T, DRAIN. state_led bit index follows this order.
- IDLE
  - start_f_p → COMM_F.
  - Else start_t_p → COMM_T.
  - Both pulses in the same cycle: Fibonacci wins.
  - Entering COMM_x from IDLE clears wr_count.
- COMM_x
  - stop_p → DRAIN (highest priority).
  - Else buf_full → WAIT_x.
  - start pulses for either source are ignored.
- WAIT_x
  - stop_p → DRAIN.
  - Else !buf_full && !skid_v → COMM_x.
  - start pulses are ignored.
- DRAIN
  - Exit to IDLE when buf_empty && !cons_valid && !skid_v.
  - Minimum residency is 1 cycle.
  - All pulses are ignored.
- f_en = (state == COMM_F). t_en = (state == COMM_T). Both are decoded from the state register only.
- Word acceptance: the valid of the selected source is accepted in COMM_x, including the cycle stop_p or buf_full arrives. A valid from the non-selected source, or in any other state, is dropped.
- Accepted word with !buf_full: written next cycle.
- Accepted word with buf_full: captured in a 1-entry skid register (skid_v = 1).
- Skid flush: in WAIT_x or DRAIN, when skid_v && !buf_full, the skid word is written and skid_v clears. The skid word always goes out before any newer word.
- A second accepted word while skid_v = 1 cannot occur, because the enable drops on entry to WAIT. If it does occur anyway, the new word is dropped and the skid is kept.
- wr_count increments on each buf_wr. It wraps modulo 2^CNT_W and holds its value in IDLE.
- src_sel updates on each write.

## Timing
- Reset values:
  - state = IDLE, state_led = 6'b000001
  - f_en = t_en = 0
  - buf_wr = 0, buf_wdata = 0
  - src_sel = 0, wr_count = 0, skid_v = 0
- Write latency: f_valid at cycle N with !buf_full → buf_wr = 1 and buf_wdata = f_data at cycle N+1. buf_wr is a single-cycle strobe.
- Enable response: a start pulse at cycle N → en = 1 from N+1. stop_p or buf_full at N → en = 0 from N+1.
- Skid flush: buf_full falls at N → skid write at N+1 → COMM_x at N+2.
- Asynchronous rst mid-operation returns to IDLE immediately and discards the skid word. Buffer contents are the buffer's concern.

## Structure
- Shared package: state encoding constants (one-hot localparams S_IDLE … S_DRAIN), DATA_W default, and the LED bit indices.
- One natural sub-module: `skid_reg`, a 1-entry holding register with load/unload/valid.
- The FSM, write mux and counter live in prod_sched.

## Test plan
- Reset, then start_f_p; f_valid with f_data = 1, 1, 2, 3 on consecutive cycles → buf_wr strobes with 1, 1, 2, 3, each one cycle later; wr_count = 4; state_led = 000010.
- In COMM_T, t_valid with t_data = 0x0042 in the same cycle buf_full rises → skid holds 0x0042, state WAIT_T, t_en = 0. buf_full falls → 0x0042 written next cycle, then COMM_T.
- start_f_p and start_t_p in the same IDLE cycle → COMM_F, f_en = 1, t_en = 0. A later start_t_p has no effect.
- stop_p in COMM_F with buf_empty = 0 → DRAIN, f_en = 0. Hold until buf_empty = 1 and cons_valid = 0 → IDLE the next cycle.
- stop_p in WAIT_F with skid_v = 1 and buf_full = 1 → DRAIN with no exit until buf_full drops, the skid word is written, and the buffer empties.
- rst asserted during DRAIN with skid_v = 1 → all outputs at reset values immediately, no buf_wr afterward.
